// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: TX/RX word FIFOs in front of the SPI shift engine.
// Issues one engine transfer per queued word and frames bursts with cs_n.
module spi_xfer_queue #(
    parameter int DEPTH  = 4,
    parameter int CS_GAP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [31:0] wdata,
    input  logic        wfast,
    input  logic        rd,
    output logic [31:0] rdata,
    output logic        tx_full,
    output logic        rx_empty,
    output logic        ovf,
    input  logic        clr,
    output logic        busy,
    output logic        cs_n,
    output logic        spi_start,
    output logic        spi_fast,
    output logic [31:0] spi_tx,
    input  logic [31:0] spi_rx,
    input  logic        spi_rdy
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(CS_GAP + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [32:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];
    logic [AW:0]   tx_wp;
    logic [AW:0]   tx_rp;
    logic [AW:0]   rx_wp;
    logic [AW:0]   rx_rp;
    logic [AW:0]   rx_cnt;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_room2;
    logic          tx_push;
    logic          tx_pop;
    logic          rx_push;
    logic          rx_pop;
    logic [32:0]   tx_head;
    logic [1:0]    state;
    logic          first;
    logic [GW-1:0] gap;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                      (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                      (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

    // Room for the word in flight plus one more before chaining a transfer.
    assign rx_cnt   = rx_wp - rx_rp;
    assign rx_room2 = (rx_cnt <= (AW+1)'(DEPTH - 2));

    assign tx_head  = tx_mem[tx_rp[AW-1:0]];
    assign rdata    = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];

    assign tx_push   = wr && !tx_full;
    assign rx_pop    = rd && !rx_empty;
    assign busy      = !tx_empty || (state != ST_IDLE);
    assign spi_start = (state == ST_LOAD);

    // Decide TX pops and RX pushes from the current FSM state.
    always_comb begin
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        unique case (1'b1)
            (state == ST_IDLE): begin
                tx_pop = !tx_empty && !rx_full;
            end
            (state == ST_WAIT): begin
                if (!first && spi_rdy) begin
                    rx_push = 1'b1;
                    tx_pop  = !tx_empty && rx_room2;
                end
            end
            default: begin
            end
        endcase
    end

    // TX storage: {fast, data} per entry.
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp[AW-1:0]] <= {wfast, wdata};
    end

    // RX storage: engine words in completion order.
    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wp[AW-1:0]] <= spi_rx;
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + (AW+1)'(1);
            if (tx_pop)  tx_rp <= tx_rp + (AW+1)'(1);
            if (rx_push) rx_wp <= rx_wp + (AW+1)'(1);
            if (rx_pop)  rx_rp <= rx_rp + (AW+1)'(1);
        end
    end

    // Sticky overflow flag: a write against a full TX queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf <= 1'b0;
        else if (wr && tx_full)
            ovf <= 1'b1;
        else if (clr)
            ovf <= 1'b0;
    end

    // Transfer sequencer, engine data registers and chip-select gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            first    <= 1'b0;
            spi_tx   <= '0;
            spi_fast <= 1'b0;
            cs_n     <= 1'b1;
            gap      <= '0;
        end else begin
            unique case (1'b1)
                (state == ST_IDLE): begin
                    if (tx_pop) begin
                        state <= ST_LOAD;
                    end else if (tx_empty && gap != '0) begin
                        gap <= gap - 1'b1;
                        if (gap == GW'(1))
                            cs_n <= 1'b1;
                    end
                end
                (state == ST_LOAD): begin
                    state <= ST_WAIT;
                    first <= 1'b1;
                end
                (state == ST_WAIT): begin
                    first <= 1'b0;
                    if (tx_pop) begin
                        state <= ST_LOAD;
                    end else if (rx_push) begin
                        state <= ST_IDLE;
                        gap   <= GW'(CS_GAP);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (tx_pop) begin
                {spi_fast, spi_tx} <= tx_head;
                cs_n               <= 1'b0;
                gap                <= '0;
            end
        end
    end

endmodule
